// File: rtl/mips_pkg.sv
// Shared types and constants for the program-counter unit.
package mips_pkg;

  localparam int PC_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_SELF  = 2'b01,
    CAUSE_RANGE = 2'b10
  } cause_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump selection, stall handling and halt detection.
// state | meaning
// RUN   | fetching; next PC evaluated every cycle
// STALL | PC held while Stall is high; resumes evaluation when it drops
// HALT  | self-loop or out-of-range target seen; frozen until reset
module pc_unit
  import mips_pkg::*;
#(
  parameter int              IMEM_BYTES = 128,
  parameter logic [PC_W-1:0] RESET_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       SEImm,
  input  logic [25:0]       JumpValue,
  input  logic              Zero,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Stall,
  output logic [PC_W-1:0]   ReadAddr,
  output logic              FetchValid,
  output logic              Halted,
  output logic [1:0]        HaltCause,
  output logic [15:0]       InstrCount,
  output logic [7:0]        TakenCount
);

  state_t          state, state_nx;
  logic [1:0]      cause, cause_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [PC_W-1:0] pc4, br_target, jmp_target, next_pc;
  logic            taken, out_of_range, self_loop;
  logic            inc_instr, inc_taken;
  logic            unused_bits;

  assign unused_bits = ^{SEImm[31:6], JumpValue[25:6]};

  assign pc4        = pc + 8'd4;
  assign br_target  = pc4 + {SEImm[5:0], 2'b00};
  assign jmp_target = {JumpValue[5:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    taken   = 1'b0;
    if (Jump) begin
      next_pc = jmp_target;
      taken   = 1'b1;
    end else if (Branch && Zero) begin
      next_pc = br_target;
      taken   = 1'b1;
    end
  end

  assign out_of_range = int'(next_pc) > (IMEM_BYTES - 4);
  assign self_loop    = (next_pc == pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc    <= RESET_ADDR;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      cause <= cause_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    cause_nx  = cause;
    inc_instr = 1'b0;
    inc_taken = 1'b0;
    case (state)
      ST_RUN, ST_STALL: begin
        if (Stall) begin
          state_nx = ST_STALL;
        end else begin
          // The halting instruction still commits, so it is counted.
          inc_instr = 1'b1;
          inc_taken = taken;
          if (out_of_range) begin
            state_nx = ST_HALT;
            cause_nx = CAUSE_RANGE;
          end else if (self_loop) begin
            state_nx = ST_HALT;
            cause_nx = CAUSE_SELF;
          end else begin
            state_nx = ST_RUN;
            pc_nx    = next_pc;
          end
        end
      end
      ST_HALT: ;
      default: state_nx = ST_RUN;
    endcase
  end

  sat_counter #(.WIDTH(16)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_instr),
    .count (InstrCount)
  );

  sat_counter #(.WIDTH(8)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken),
    .count (TakenCount)
  );

  assign ReadAddr   = pc;
  assign FetchValid = (state == ST_RUN);
  assign Halted     = (state == ST_HALT);
  assign HaltCause  = cause;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed stimulus queues expectations, a monitor checks them.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] SEImm = '0;
  logic [25:0] JumpValue = '0;
  logic        Zero = 1'b0, Branch = 1'b0, Jump = 1'b0, Stall = 1'b0;
  logic [7:0]  ReadAddr;
  logic        FetchValid, Halted;
  logic [1:0]  HaltCause;
  logic [15:0] InstrCount;
  logic [7:0]  TakenCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [15:0] ic;
    logic [7:0]  tc;
    logic        h;
    logic [1:0]  c;
    logic        fv;
  } exp_t;

  exp_t exp_q[$];

  pc_unit #(.IMEM_BYTES(128), .RESET_ADDR(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SEImm      (SEImm),
    .JumpValue  (JumpValue),
    .Zero       (Zero),
    .Branch     (Branch),
    .Jump       (Jump),
    .Stall      (Stall),
    .ReadAddr   (ReadAddr),
    .FetchValid (FetchValid),
    .Halted     (Halted),
    .HaltCause  (HaltCause),
    .InstrCount (InstrCount),
    .TakenCount (TakenCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
    end
  endtask

  // Monitor: outputs are all register-derived, so they are compared as soon as an expectation appears.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() > 0);
      e = exp_q.pop_front();
      chk(e.name, "ReadAddr",   int'(ReadAddr),   int'(e.addr));
      chk(e.name, "InstrCount", int'(InstrCount), int'(e.ic));
      chk(e.name, "TakenCount", int'(TakenCount), int'(e.tc));
      chk(e.name, "Halted",     int'(Halted),     int'(e.h));
      chk(e.name, "HaltCause",  int'(HaltCause),  int'(e.c));
      chk(e.name, "FetchValid", int'(FetchValid), int'(e.fv));
    end
  end

  task automatic expect_out(input string name, input logic [7:0] addr, input int ic, input int tc,
                            input logic h, input logic [1:0] c, input logic fv);
    exp_t e;
    e.name = name; e.addr = addr; e.ic = 16'(ic); e.tc = 8'(tc);
    e.h = h; e.c = c; e.fv = fv;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic j, input logic b, input logic z,
                       input logic [31:0] se, input logic [25:0] jv);
    Stall = st; Jump = j; Branch = b; Zero = z; SEImm = se; JumpValue = jv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted mid-cycle and checked before any clock edge arrives.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #2;
    expect_out(name, 8'h00, 0, 0, 1'b0, 2'b00, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, '0, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    int tc_exp;
    do_reset("reset_initial");

    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("seq_fetch", 8'(4 * i), i, 0, 1'b0, 2'b00, 1'b1);
    end

    do_reset("reset_mid_run");
    tick(); expect_out("pre_branch", 8'h04, 1, 0, 1'b0, 2'b00, 1'b1);
    tick(); expect_out("pre_branch", 8'h08, 2, 0, 1'b0, 2'b00, 1'b1);
    drive(0, 0, 1, 1, 32'hFFFF_FFFE, '0);
    tick(); expect_out("branch_taken", 8'h04, 3, 1, 1'b0, 2'b00, 1'b1);
    drive(0, 0, 0, 0, '0, '0);
    tick(); expect_out("after_branch", 8'h08, 4, 1, 1'b0, 2'b00, 1'b1);
    drive(0, 0, 1, 0, 32'hFFFF_FFFE, '0);
    tick(); expect_out("branch_not_taken", 8'h0C, 5, 1, 1'b0, 2'b00, 1'b1);

    drive(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall_hold", 8'h0C, 5, 1, 1'b0, 2'b00, 1'b0);
    end
    drive(0, 0, 0, 0, '0, '0);
    tick(); expect_out("stall_resume", 8'h10, 6, 1, 1'b0, 2'b00, 1'b1);

    drive(0, 1, 1, 1, 32'h0000_0010, 26'h20);
    tick(); expect_out("jump_out_of_range", 8'h10, 7, 2, 1'b1, 2'b10, 1'b0);
    drive(1, 0, 0, 0, '0, '0);
    tick(); expect_out("halt_ignores_stall", 8'h10, 7, 2, 1'b1, 2'b10, 1'b0);
    drive(0, 0, 0, 0, '0, '0);
    tick(); expect_out("halt_frozen", 8'h10, 7, 2, 1'b1, 2'b10, 1'b0);
    do_reset("reset_in_halt");

    drive(0, 1, 0, 0, '0, 26'h09);
    tick(); expect_out("jump_to_24", 8'h24, 1, 1, 1'b0, 2'b00, 1'b1);
    drive(1, 1, 0, 0, '0, 26'h09);
    tick(); expect_out("stall_beats_halt", 8'h24, 1, 1, 1'b0, 2'b00, 1'b0);
    drive(0, 1, 0, 0, '0, 26'h09);
    tick(); expect_out("self_loop_halt", 8'h24, 2, 2, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2), 1'(i % 3 == 0), 1'b1, 1'b1, 32'h1, 26'h02);
      tick(); expect_out("self_loop_hold", 8'h24, 2, 2, 1'b1, 2'b01, 1'b0);
    end

    do_reset("reset_before_stall");
    tick(); expect_out("pre_stall", 8'h04, 1, 0, 1'b0, 2'b00, 1'b1);
    drive(1, 0, 0, 0, '0, '0);
    tick(); expect_out("in_stall", 8'h04, 1, 0, 1'b0, 2'b00, 1'b0);
    do_reset("reset_mid_stall");
    tick(); expect_out("post_reset_fetch", 8'h04, 1, 0, 1'b0, 2'b00, 1'b1);

    do_reset("reset_before_sat");
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 0, 0, '0, (i % 2 == 0) ? 26'h01 : 26'h00);
      tick();
      tc_exp = (i + 1 > 255) ? 255 : i + 1;
      expect_out("taken_saturate", (i % 2 == 0) ? 8'h04 : 8'h00, i + 1, tc_exp, 1'b0, 2'b00, 1'b1);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
